// File: rtl/quad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : quad_pkg                                                     |
// | Description : Shared types, Gray phase constants and the transition        |
// |               classifier for the quadrature decoder.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package quad_pkg;

  // Decoder control FSM.
  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Classification of one {a,b} sample against the previous one.
  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_UP   = 2'd1,
    MV_DOWN = 2'd2,
    MV_ERR  = 2'd3
  } move_t;

  // Quadrature phases in forward (count-up) order: 00 -> 10 -> 11 -> 01 -> 00.
  localparam logic [1:0] c_ph_00 = 2'b00;
  localparam logic [1:0] c_ph_10 = 2'b10;
  localparam logic [1:0] c_ph_11 = 2'b11;
  localparam logic [1:0] c_ph_01 = 2'b01;

  // Phase that follows ph when moving forward.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      c_ph_00: nxt = c_ph_10;
      c_ph_10: nxt = c_ph_11;
      c_ph_11: nxt = c_ph_01;
      default: nxt = c_ph_00;
    endcase
    return nxt;
  endfunction

  // Any single-bit change is a legal step; which neighbour it reached gives
  // the direction. Both bits flipping means an edge was missed.
  function automatic move_t decode_move(input logic [1:0] prev, input logic [1:0] cur);
    move_t mv;
    if (cur == prev) begin
      mv = MV_NONE;
    end else if ((cur ^ prev) == 2'b11) begin
      mv = MV_ERR;
    end else if (cur == next_up(prev)) begin
      mv = MV_UP;
    end else begin
      mv = MV_DOWN;
    end
    return mv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync2                                                        |
// | Description : Two-flop synchronizer, 1 bit wide.                           |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : CLK   - system clock                                         |
// |               RESET - synchronous active-high reset, clears both stages    |
// |               d     - asynchronous input                                   |
// |               q     - synchronized output (two CLK edges of latency)       |
// +----------------------------------------------------------------------------+
module sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : quad_decoder                                                 |
// | Description : Quadrature encoder decoder with saturating position count,   |
// |               step/direction pulses and a sticky illegal-transition flag.  |
// | Revision    : 1.0 - initial release                                        |
// | Parameters  : N     - position counter width in bits                       |
// | Ports       : CLK   - system clock (rising edge)                           |
// |               RESET - synchronous active-high reset                        |
// |               A, B  - encoder channels, asynchronous to CLK                |
// |               CLR   - synchronous clear of POS and ERR                     |
// |               POS   - saturating position count (N bits)                   |
// |               STEP  - one-cycle pulse per valid transition                 |
// |               DIR   - direction of last valid step (1 = up)                |
// |               ERR   - sticky illegal-transition flag                       |
// +----------------------------------------------------------------------------+
module quad_decoder
  import quad_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         A,
  input  logic         B,
  input  logic         CLR,
  output logic [N-1:0] POS,
  output logic         STEP,
  output logic         DIR,
  output logic         ERR
);

  localparam logic [N-1:0] c_pos_max  = '1;
  localparam logic [N-1:0] c_pos_zero = '0;
  localparam logic [N-1:0] c_pos_one  = {{(N-1){1'b0}}, 1'b1};

  logic       w_a;
  logic       w_b;
  logic [1:0] w_ab;
  move_t      w_move;

  state_t     r_state;
  logic [1:0] r_fill;
  logic [1:0] r_prev;
  logic [N-1:0] r_pos;
  logic       r_step;
  logic       r_dir;
  logic       r_err;

  sync2 u_sync_a (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (A),
    .q     (w_a)
  );

  sync2 u_sync_b (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (B),
    .q     (w_b)
  );

  assign w_ab = {w_a, w_b};

  always_comb begin
    w_move = decode_move(r_prev, w_ab);
  end

  // Reset zeroes the synchronizers, so their output is not a real sample of
  // A/B until two edges later. r_fill tracks that refill so INIT captures a
  // genuine phase into PREV; otherwise the flush from 00 to the true input
  // would be decoded as a spurious step right after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= INIT;
      r_fill  <= 2'b00;
      r_prev  <= c_ph_00;
      r_pos   <= c_pos_zero;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fill <= {r_fill[0], 1'b1};
      r_step <= 1'b0;
      case (r_state)
        INIT: begin
          r_prev <= w_ab;
          if (r_fill[1]) begin
            r_state <= TRACK;
          end
        end
        TRACK: begin
          r_prev <= w_ab;
          case (w_move)
            MV_UP: begin
              r_step <= 1'b1;
              r_dir  <= 1'b1;
              if (r_pos != c_pos_max) begin
                r_pos <= r_pos + c_pos_one;
              end
            end
            MV_DOWN: begin
              r_step <= 1'b1;
              r_dir  <= 1'b0;
              if (r_pos != c_pos_zero) begin
                r_pos <= r_pos - c_pos_one;
              end
            end
            MV_ERR: begin
              r_err <= 1'b1;
            end
            default: begin
            end
          endcase
        end
        default: begin
          r_state <= INIT;
        end
      endcase
      // Clear wins over any count change or error made this cycle; STEP/DIR
      // and PREV tracking are left alone so no transition is lost.
      if (CLR) begin
        r_pos <= c_pos_zero;
        r_err <= 1'b0;
      end
    end
  end

  assign POS  = r_pos;
  assign STEP = r_step;
  assign DIR  = r_dir;
  assign ERR  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_quad_decoder                                              |
// | Description : Self-checking bench for quad_decoder (N=8 and N=4 copies).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_quad_decoder;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic A = 1'b0;
  logic B = 1'b0;
  logic CLR = 1'b0;

  logic [7:0] pos8;
  logic       step8, dir8, err8;
  logic [3:0] pos4;
  logic       step4, dir4, err4;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  quad_decoder #(.N(8)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .CLR(CLR),
    .POS(pos8), .STEP(step8), .DIR(dir8), .ERR(err8)
  );

  quad_decoder #(.N(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .CLR(CLR),
    .POS(pos4), .STEP(step4), .DIR(dir4), .ERR(err4)
  );

  // Forward phase i (mod 4): 00, 10, 11, 01.
  function automatic logic [1:0] phase_val(input int i);
    logic [1:0] v;
    case (i % 4)
      0:       v = 2'b00;
      1:       v = 2'b10;
      2:       v = 2'b11;
      default: v = 2'b01;
    endcase
    return v;
  endfunction

  function automatic int phase_of(input logic [1:0] v);
    int p;
    case (v)
      2'b00:   p = 0;
      2'b10:   p = 1;
      2'b11:   p = 2;
      default: p = 3;
    endcase
    return p;
  endfunction

  // Distance travelled around the phase circle: 0 none, 1 up, 3 down, 2 illegal.
  function automatic int move_of(input logic [1:0] o, input logic [1:0] n);
    return (phase_of(n) - phase_of(o) + 4) % 4;
  endfunction

  // Reference model: the input seen at edge k is decoded against the input at
  // edge k-1, and the result appears after edge k+2. The first comparison after
  // reset is made at the fourth edge with RESET low.
  int m_k = 0;
  int m_pos8 = 0;
  int m_pos4 = 0;
  logic m_step = 1'b0;
  logic m_dir = 1'b0;
  logic m_err = 1'b0;
  logic [1:0] m_h0 = 2'b00, m_h1 = 2'b00, m_h2 = 2'b00;

  always @(posedge CLK) begin
    if (RESET) begin
      m_k    <= 0;
      m_pos8 <= 0;
      m_pos4 <= 0;
      m_step <= 1'b0;
      m_dir  <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_h0 <= {A, B};
      m_h1 <= m_h0;
      m_h2 <= m_h1;
      m_step <= 1'b0;
      if (m_k >= 3) begin
        case (move_of(m_h2, m_h1))
          1: begin
            m_step <= 1'b1;
            m_dir  <= 1'b1;
            if (m_pos8 < 255) m_pos8 <= m_pos8 + 1;
            if (m_pos4 < 15)  m_pos4 <= m_pos4 + 1;
          end
          3: begin
            m_step <= 1'b1;
            m_dir  <= 1'b0;
            if (m_pos8 > 0) m_pos8 <= m_pos8 - 1;
            if (m_pos4 > 0) m_pos4 <= m_pos4 - 1;
          end
          2: m_err <= 1'b1;
          default: begin end
        endcase
      end
      if (CLR) begin
        m_pos8 <= 0;
        m_pos4 <= 0;
        m_err  <= 1'b0;
      end
      if (m_k < 3) m_k <= m_k + 1;
    end
  end

  task automatic set_ab(input logic [1:0] v);
    A = v[1];
    B = v[0];
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset(input logic [1:0] v);
    set_ab(v);
    CLR = 1'b0;
    RESET = 1'b1;
    ticks(2);
    RESET = 1'b0;
  endtask

  task automatic test_reset;
    set_ab(2'b10);
    CLR = 1'b1;
    RESET = 1'b1;
    ticks(2);
    checks++; if (pos8 !== 8'd0) begin failures++; $display("FAIL rst_pos: got %0d expected 0", pos8); end
    checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL rst_step: got %b expected 0", step8); end
    checks++; if (dir8 !== 1'b0) begin failures++; $display("FAIL rst_dir: got %b expected 0", dir8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", err8); end
    checks++; if (pos4 !== 4'd0) begin failures++; $display("FAIL rst_pos4: got %0d expected 0", pos4); end
    RESET = 1'b0;
    CLR = 1'b0;
    // Input already sits at 10: nothing must step while the sampler refills.
    for (int c = 0; c < 6; c++) begin
      ticks(1);
      checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL rst_quiet_step: got %b expected 0 (cycle %0d)", step8, c); end
    end
  endtask

  task automatic test_forward;
    int nsteps = 0;
    do_reset(2'b00);
    ticks(4);
    for (int i = 1; i <= 4; i++) begin
      set_ab(phase_val(i));
      for (int c = 1; c <= 4; c++) begin
        ticks(1);
        checks++;
        if (step8 !== (c == 3)) begin
          failures++; $display("FAIL fwd_step_timing: got %b expected %b (transition %0d, edge %0d)", step8, (c == 3), i, c);
        end
        if (step8 === 1'b1) begin
          nsteps++;
          checks++; if (dir8 !== 1'b1) begin failures++; $display("FAIL fwd_dir: got %b expected 1", dir8); end
        end
      end
    end
    checks++; if (nsteps != 4) begin failures++; $display("FAIL fwd_nsteps: got %0d expected 4", nsteps); end
    checks++; if (pos8 !== 8'd4) begin failures++; $display("FAIL fwd_pos: got %0d expected 4", pos8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL fwd_err: got %b expected 0", err8); end
  endtask

  task automatic test_reverse_sat;
    int nsteps = 0;
    do_reset(2'b00);
    ticks(4);
    for (int i = 1; i <= 3; i++) begin
      set_ab(phase_val(4 - i));
      for (int c = 1; c <= 4; c++) begin
        ticks(1);
        checks++; if (pos8 !== 8'd0) begin failures++; $display("FAIL rev_pos: got %0d expected 0", pos8); end
        if (step8 === 1'b1) begin
          nsteps++;
          checks++; if (dir8 !== 1'b0) begin failures++; $display("FAIL rev_dir: got %b expected 0", dir8); end
        end
      end
    end
    checks++; if (nsteps != 3) begin failures++; $display("FAIL rev_nsteps: got %0d expected 3", nsteps); end
  endtask

  task automatic test_upper_sat;
    int nsteps = 0;
    int exp_pos;
    do_reset(2'b00);
    ticks(4);
    for (int i = 1; i <= 24; i++) begin
      if (i <= 20) set_ab(phase_val(i));
      for (int c = 1; c <= 2; c++) begin
        ticks(1);
        if (step4 === 1'b1) begin
          nsteps++;
          exp_pos = (nsteps > 15) ? 15 : nsteps;
          checks++; if (pos4 !== 4'(exp_pos)) begin failures++; $display("FAIL sat_pos_run: got %0d expected %0d", pos4, exp_pos); end
          checks++; if (dir4 !== 1'b1) begin failures++; $display("FAIL sat_dir: got %b expected 1", dir4); end
        end
      end
    end
    checks++; if (nsteps != 20) begin failures++; $display("FAIL sat_nsteps: got %0d expected 20", nsteps); end
    checks++; if (pos4 !== 4'd15) begin failures++; $display("FAIL sat_pos4: got %0d expected 15", pos4); end
    checks++; if (pos8 !== 8'd20) begin failures++; $display("FAIL sat_pos8: got %0d expected 20", pos8); end
  endtask

  task automatic test_illegal;
    do_reset(2'b11);
    ticks(4);
    set_ab(2'b01);
    ticks(3);
    set_ab(2'b00);
    ticks(4);
    checks++; if (pos8 !== 8'd2) begin failures++; $display("FAIL ill_pre_pos: got %0d expected 2", pos8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL ill_pre_err: got %b expected 0", err8); end
    set_ab(2'b11);
    for (int c = 1; c <= 4; c++) begin
      ticks(1);
      checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL ill_step: got %b expected 0", step8); end
    end
    checks++; if (err8 !== 1'b1) begin failures++; $display("FAIL ill_err: got %b expected 1", err8); end
    checks++; if (pos8 !== 8'd2) begin failures++; $display("FAIL ill_pos: got %0d expected 2", pos8); end
    ticks(6);
    checks++; if (err8 !== 1'b1) begin failures++; $display("FAIL ill_sticky: got %b expected 1", err8); end
    CLR = 1'b1;
    ticks(1);
    CLR = 1'b0;
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL ill_clr_err: got %b expected 0", err8); end
    checks++; if (pos8 !== 8'd0) begin failures++; $display("FAIL ill_clr_pos: got %0d expected 0", pos8); end
  endtask

  task automatic test_clr_step;
    do_reset(2'b00);
    ticks(4);
    for (int i = 1; i <= 7; i++) begin
      set_ab(phase_val(i));
      ticks(3);
    end
    checks++; if (pos8 !== 8'd7) begin failures++; $display("FAIL clr_pre_pos: got %0d expected 7", pos8); end
    set_ab(phase_val(8));
    ticks(2);
    CLR = 1'b1;  // sampled on the same edge that registers the step
    ticks(1);
    CLR = 1'b0;
    checks++; if (step8 !== 1'b1) begin failures++; $display("FAIL clr_step: got %b expected 1", step8); end
    checks++; if (dir8 !== 1'b1) begin failures++; $display("FAIL clr_dir: got %b expected 1", dir8); end
    checks++; if (pos8 !== 8'd0) begin failures++; $display("FAIL clr_pos: got %0d expected 0", pos8); end
    ticks(2);
    set_ab(phase_val(9));
    ticks(3);
    checks++; if (step8 !== 1'b1) begin failures++; $display("FAIL clr_next_step: got %b expected 1", step8); end
    checks++; if (pos8 !== 8'd1) begin failures++; $display("FAIL clr_next_pos: got %0d expected 1", pos8); end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    do_reset(2'b00);
    ticks(4);
    for (int i = 1; i <= 9; i++) begin
      set_ab(phase_val(i));
      ticks(3);
    end
    checks++; if (pos8 !== 8'd9) begin failures++; $display("FAIL mid_pre_pos: got %0d expected 9", pos8); end
    set_ab(2'b00);  // down step now in flight
    ticks(1);
    RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      A = ~A;
      ticks(1);
    end
    RESET = 1'b0;   // {A,B} = 10 here
    for (int c = 0; c < 8; c++) begin
      ticks(1);
      checks++; if (step8 !== 1'b0) begin failures++; $display("FAIL mid_init_step: got %b expected 0 (cycle %0d)", step8, c); end
      checks++; if (pos8 !== 8'd0) begin failures++; $display("FAIL mid_init_pos: got %0d expected 0", pos8); end
    end
    set_ab(2'b11);
    for (int c = 0; c < 4; c++) begin
      ticks(1);
      if (step8 === 1'b1) begin
        seen = 1;
        checks++; if (dir8 !== 1'b1) begin failures++; $display("FAIL mid_dir: got %b expected 1", dir8); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_first_step: got 0 expected 1"); end
    checks++; if (pos8 !== 8'd1) begin failures++; $display("FAIL mid_pos: got %0d expected 1", pos8); end
  endtask

  task automatic test_random;
    int cur = 0;
    int r;
    do_reset(2'b00);
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      // Upward drift in the first half, downward in the second, so both
      // saturation limits of the narrow counter are exercised.
      if (r < ((n < 400) ? 45 : 20))      cur = (cur + 1) % 4;
      else if (r < 65)                    cur = (cur + 3) % 4;
      else if (r < 70)                    cur = (cur + 2) % 4;
      set_ab(phase_val(cur));
      CLR   = ($urandom_range(0, 99) < 3);
      RESET = ($urandom_range(0, 199) < 2);
      ticks(1);
      checks++; if (pos8 !== 8'(m_pos8)) begin failures++; $display("FAIL rnd_pos8: got %0d expected %0d (cycle %0d)", pos8, m_pos8, n); end
      checks++; if (pos4 !== 4'(m_pos4)) begin failures++; $display("FAIL rnd_pos4: got %0d expected %0d (cycle %0d)", pos4, m_pos4, n); end
      checks++; if (step8 !== m_step || step4 !== m_step) begin failures++; $display("FAIL rnd_step: got %b/%b expected %b (cycle %0d)", step8, step4, m_step, n); end
      checks++; if (dir8 !== m_dir || dir4 !== m_dir) begin failures++; $display("FAIL rnd_dir: got %b/%b expected %b (cycle %0d)", dir8, dir4, m_dir, n); end
      checks++; if (err8 !== m_err || err4 !== m_err) begin failures++; $display("FAIL rnd_err: got %b/%b expected %b (cycle %0d)", err8, err4, m_err, n); end
    end
    RESET = 1'b0;
    CLR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_sat();
    test_upper_sat();
    test_illegal();
    test_clr_step();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
